// File: rtl/det_delay_scan_ctrl.sv
// Detector-delay scan controller: steps delay_det across a range, integrates
// gated click edges over a fixed number of sync triggers per point, reports each point.
module det_delay_scan_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] scan_start,
    input  logic [31:0] scan_stop,
    input  logic [31:0] scan_step,
    input  logic [15:0] dwell_syncs,
    input  logic        os_sync,
    input  logic        det_gate,
    input  logic        click,
    output logic [31:0] delay_det,
    output logic        busy,
    output logic        done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_delay,
    output logic [31:0] res_count,
    output logic        res_sat
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_REPORT,
        ST_NEXT,
        ST_FINISH
    } state_e;

    state_e      state_q;
    logic [31:0] stop_q;
    logic [31:0] step_q;
    logic [15:0] dwell_q;
    logic [31:0] delay_q;
    logic [15:0] sync_cnt_q;
    logic [31:0] click_cnt_q;
    logic        sat_q;
    logic        click_prev_q;
    logic        done_q;
    logic        res_valid_q;
    logic [31:0] res_delay_q;
    logic [31:0] res_count_q;
    logic        res_sat_q;

    logic        click_hit;
    logic [31:0] click_cnt_d;
    logic        sat_d;
    logic [15:0] dwell_last;
    logic        sync_last;
    logic [32:0] step_sum;

    assign click_hit   = click & ~click_prev_q & det_gate;
    assign click_cnt_d = (click_hit && click_cnt_q != 32'hFFFF_FFFF) ? click_cnt_q + 32'd1 : click_cnt_q;
    assign sat_d       = sat_q | (click_cnt_d == 32'hFFFF_FFFF);
    // A dwell of zero behaves as a single sync per point.
    assign dwell_last  = (dwell_q == 16'd0) ? 16'd0 : dwell_q - 16'd1;
    assign sync_last   = os_sync && (sync_cnt_q == dwell_last);
    assign step_sum    = {1'b0, delay_q} + {1'b0, step_q};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            delay_q      <= '0;
            sync_cnt_q   <= '0;
            click_cnt_q  <= '0;
            sat_q        <= 1'b0;
            click_prev_q <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_delay_q  <= '0;
            res_count_q  <= '0;
            res_sat_q    <= 1'b0;
        end else begin
            click_prev_q <= click;
            done_q       <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                res_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            stop_q  <= scan_stop;
                            step_q  <= scan_step;
                            dwell_q <= dwell_syncs;
                            if (scan_start > scan_stop) begin
                                state_q <= ST_FINISH;
                            end else begin
                                delay_q <= scan_start;
                                state_q <= ST_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (os_sync) begin
                            sync_cnt_q  <= '0;
                            click_cnt_q <= '0;
                            sat_q       <= 1'b0;
                            state_q     <= ST_DWELL;
                        end
                    end
                    ST_DWELL: begin
                        click_cnt_q <= click_cnt_d;
                        sat_q       <= sat_d;
                        if (sync_last) begin
                            res_valid_q <= 1'b1;
                            res_delay_q <= delay_q;
                            res_count_q <= click_cnt_d;
                            res_sat_q   <= sat_d;
                            state_q     <= ST_REPORT;
                        end else if (os_sync) begin
                            sync_cnt_q <= sync_cnt_q + 16'd1;
                        end
                    end
                    ST_REPORT: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            state_q     <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (step_q == 32'd0 || step_sum[32] || step_sum[31:0] > stop_q) begin
                            state_q <= ST_FINISH;
                        end else begin
                            delay_q <= step_sum[31:0];
                            state_q <= ST_SETTLE;
                        end
                    end
                    ST_FINISH: begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign delay_det = delay_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_delay = res_delay_q;
    assign res_count = res_count_q;
    assign res_sat   = res_sat_q;

endmodule
